// File: rtl/pool_window_seq.sv
// Streaming max/avg pooling of 2**WIN_LOG2 signed elements; result registered 1 cycle after the last element.
// Result is held under output backpressure; only the window-closing element stalls while a result is held.
module pool_window_seq #(
  parameter int N        = 8,
  parameter int Q        = 4,
  parameter int WIN_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                mode,
  input  logic                clr,
  input  logic signed [N-1:0] in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic signed [N-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy
);

  localparam int AW = N + WIN_LOG2;
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
  localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);

  if (WIN_LOG2 < 1 || WIN_LOG2 > 6 || Q < 0 || Q >= N) begin : g_bad_param
    $error("pool_window_seq: illegal WIN_LOG2 or Q");
  end

  logic [WIN_LOG2-1:0]  cnt;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] acc_nxt;
  logic signed [N-1:0]  avg_res;
  logic signed [N-1:0]  result;
  logic                 mode_q;
  logic                 mode_eff;
  logic                 first;
  logic                 last;
  logic                 take;
  logic                 done;

  assign first = (cnt == '0);
  assign last  = (cnt == CNT_LAST);
  assign busy  = !first;

  // Partial accumulation may proceed while a result is held; only the closing element would overwrite it.
  assign in_ready = !last || !out_valid || out_ready;
  assign take     = ce && !clr && in_valid && in_ready;
  assign done     = take && last;

  assign mode_eff = first ? mode : mode_q;
  assign ext      = {{WIN_LOG2{in_data[N-1]}}, in_data};

  always_comb begin
    acc_nxt = ext;
    if (!first) begin
      if (mode_eff) acc_nxt = (ext > acc) ? ext : acc;
      else          acc_nxt = acc + ext;
    end
  end

  // Arithmetic shift floors toward -inf; the mean of N-bit values always fits back in N bits.
  assign avg_res = N'(acc_nxt >>> WIN_LOG2);
  assign result  = mode_eff ? acc_nxt[N-1:0] : avg_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      acc       <= '0;
      mode_q    <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (ce) begin
      if (clr) begin
        cnt <= '0;
        acc <= '0;
      end else if (take) begin
        cnt <= cnt + CNT_ONE;
        acc <= acc_nxt;
        if (first) mode_q <= mode;
      end
      if (done) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool_window_seq.sv
// Scoreboard bench: a 4-element and a 16-element pooling instance checked against a list-based reference model.
module tb_pool_window_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, ce, mode, clr, in_valid, out_ready, sel;
  logic [7:0] in_data;

  logic       in_valid_a, clr_a, out_ready_a, in_ready_a, out_valid_a, busy_a;
  logic       in_valid_b, clr_b, out_ready_b, in_ready_b, out_valid_b, busy_b;
  logic [7:0] out_data_a, out_data_b;

  assign in_valid_a  = in_valid & ~sel;
  assign clr_a       = clr & ~sel;
  assign out_ready_a = sel ? 1'b1 : out_ready;
  assign in_valid_b  = in_valid & sel;
  assign clr_b       = clr & sel;
  assign out_ready_b = sel ? out_ready : 1'b1;

  pool_window_seq #(.N(8), .Q(4), .WIN_LOG2(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mode(mode), .clr(clr_a),
    .in_data(in_data), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready_a), .busy(busy_a));

  pool_window_seq #(.N(8), .Q(4), .WIN_LOG2(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce), .mode(mode), .clr(clr_b),
    .in_data(in_data), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready_b), .busy(busy_b));

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   win[2][64];
  int   wcnt[2];
  bit   wmode[2];
  bit   fresh[2];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  bit   hs_a, hs_b;
  bit   rand_bg = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference: collect the window as a list of integers, then take max or floor(mean).
  task automatic model_step(input int d, input bit c, input bit hs, input bit cl,
                            input bit m, input logic [7:0] x);
    int   k, r, sum;
    exp_t e;
    if (!c || !rst_n) return;
    if (cl) begin
      wcnt[d] = 0;
      return;
    end
    if (!hs) return;
    if (wcnt[d] == 0) wmode[d] = m;
    win[d][wcnt[d]] = int'($signed(x));
    wcnt[d]++;
    k = (d == 0) ? 4 : 16;
    if (wcnt[d] == k) begin
      if (wmode[d]) begin
        r = win[d][0];
        for (int i = 1; i < k; i++) if (win[d][i] > r) r = win[d][i];
      end else begin
        sum = 0;
        for (int i = 0; i < k; i++) sum += win[d][i];
        r = sum / k;
        if ((sum % k) != 0 && sum < 0) r = r - 1;
      end
      e.data = r[7:0];
      e.cyc  = cyc;
      if (d == 0) qa.push_back(e);
      else        qb.push_back(e);
      wcnt[d] = 0;
    end
  endtask

  always @(negedge clk) begin
    #4;
    hs_a = ce & in_valid_a & in_ready_a & ~clr_a;
    hs_b = ce & in_valid_b & in_ready_b & ~clr_b;
    model_step(0, ce, hs_a, clr_a, mode, in_data);
    model_step(1, ce, hs_b, clr_b, mode, in_data);
  end

  task automatic mon(input int d);
    logic       ov, ordy;
    logic [7:0] od;
    int         n;
    exp_t       e;
    ov   = d ? out_valid_b : out_valid_a;
    ordy = d ? out_ready_b : out_ready_a;
    od   = d ? out_data_b  : out_data_a;
    n    = d ? qb.size()   : qa.size();
    if (!ov) return;
    if (n == 0) begin
      vectors++;
      errors++;
      $display("FAIL unexpected_out_valid dut%0d: got out_data %0h, required no result", d, od);
      return;
    end
    e = d ? qb[0] : qa[0];
    check($sformatf("out_data_dut%0d", d), 32'(od), 32'(e.data));
    if (fresh[d]) begin
      check($sformatf("latency_dut%0d", d), cyc, e.cyc + 1);
      fresh[d] = 1'b0;
    end
    if (ordy && ce) begin
      if (d == 0) void'(qa.pop_front());
      else        void'(qb.pop_front());
      fresh[d] = 1'b1;
    end
  endtask

  always @(negedge clk) begin
    #4;
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  always @(negedge clk) begin
    if (rand_bg) begin
      ce        = ($urandom_range(0, 7) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic send(input logic [7:0] x, input logic m);
    bit got;
    in_data  = x;
    mode     = m;
    in_valid = 1'b1;
    got      = 1'b0;
    for (int t = 0; t < 300 && !got; t++) begin
      @(posedge clk);
      got = sel ? hs_b : hs_a;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (!got) begin
      vectors++;
      errors++;
      $display("FAIL send_timeout: element %0h not accepted, required acceptance within 300 cycles", x);
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid_a), 0);
    check({tag, "_out_data"},  32'(out_data_a),  0);
    check({tag, "_busy"},      32'(busy_a),      0);
    check({tag, "_in_ready"},  32'(in_ready_a),  1);
    qa.delete();
    qb.delete();
    wcnt[0]  = 0;
    wcnt[1]  = 0;
    fresh[0] = 1'b1;
    fresh[1] = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit got;
    logic [7:0] x;
    rst_n = 1'b0; ce = 1'b1; mode = 1'b0; clr = 1'b0; in_valid = 1'b0;
    out_ready = 1'b1; sel = 1'b0; in_data = 8'h00;
    wcnt[0] = 0; wcnt[1] = 0; fresh[0] = 1'b1; fresh[1] = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_out_valid_a", 32'(out_valid_a), 0);
    check("reset_out_data_a",  32'(out_data_a),  0);
    check("reset_busy_a",      32'(busy_a),      0);
    check("reset_in_ready_a",  32'(in_ready_a),  1);
    check("reset_out_valid_b", 32'(out_valid_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Max pool with mixed signs, then a single-cycle drain.
    send(8'h05, 1'b1); send(8'hFE, 1'b1); send(8'h7F, 1'b1); send(8'h80, 1'b1);
    check("t1_out_valid", 32'(out_valid_a), 1);
    check("t1_out_data",  32'(out_data_a),  32'h7F);
    @(negedge clk);
    check("t1_out_valid_drop", 32'(out_valid_a), 0);

    send(8'hF0, 1'b1); send(8'hFF, 1'b1); send(8'h80, 1'b1); send(8'hFE, 1'b1);
    send(8'h04, 1'b0); send(8'h08, 1'b0); send(8'h0C, 1'b0); send(8'h10, 1'b0);
    send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFF, 1'b0); send(8'hFE, 1'b0);
    @(negedge clk);

    // Backpressure: hold, partial next window, closing element stalls until drain.
    out_ready = 1'b0;
    send(8'h11, 1'b1); send(8'h22, 1'b1); send(8'h33, 1'b1); send(8'h44, 1'b1);
    repeat (10) @(negedge clk);
    check("t4_hold_data", 32'(out_data_a), 32'h44);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0);
    in_data = 8'h05; mode = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("t4_in_ready_stall", 32'(in_ready_a), 0);
    check("t4_busy",           32'(busy_a),     1);
    out_ready = 1'b1;
    @(posedge clk);
    got = hs_a;
    @(negedge clk);
    in_valid = 1'b0;
    check("t4_drain_accept", 32'(got),         1);
    check("t4_next_valid",   32'(out_valid_a), 1);
    check("t4_next_data",    32'(out_data_a),  32'h02);
    @(negedge clk);

    // Mode is latched on the first element only; clr aborts a partial window.
    send(8'h10, 1'b1); send(8'h20, 1'b0); send(8'h30, 1'b0); send(8'h40, 1'b0);
    send(8'h11, 1'b0); send(8'h22, 1'b0);
    check("t5_busy_before_clr", 32'(busy_a), 1);
    clr = 1'b1; in_valid = 1'b1; in_data = 8'h7F;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    check("t5_busy_after_clr", 32'(busy_a), 0);
    send(8'h08, 1'b0); send(8'h08, 1'b0); send(8'h10, 1'b0); send(8'h10, 1'b0);
    @(negedge clk);

    // Asynchronous reset mid-window and mid-hold.
    send(8'h01, 1'b0); send(8'h02, 1'b0);
    check("t6_busy_mid", 32'(busy_a), 1);
    async_reset("t6_rst_window");
    out_ready = 1'b0;
    send(8'h01, 1'b1); send(8'h02, 1'b1); send(8'h03, 1'b1); send(8'h04, 1'b1);
    check("t6_hold_valid", 32'(out_valid_a), 1);
    async_reset("t6_rst_hold");
    out_ready = 1'b1;
    @(negedge clk);
    check("t6_no_spurious_valid", 32'(out_valid_a), 0);
    send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    @(negedge clk);

    // 16-element windows.
    sel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      x = (i == 5) ? 8'h7F : (i == 9) ? 8'h80 : 8'(int'($urandom_range(0, 200)) - 100);
      send(x, 1'b1);
    end
    for (int i = 0; i < 16; i++) begin
      x = (i == 11) ? 8'hFF : 8'(8'h80 + 8'($urandom_range(0, 126)));
      send(x, 1'b1);
    end
    for (int i = 0; i < 16; i++) send(8'($urandom), 1'b0);
    for (int i = 0; i < 16; i++) send((i == 3) ? 8'hFE : 8'hFF, 1'b0);
    @(negedge clk);

    // Randomised traffic on both instances with ce/out_ready jitter and occasional clr.
    rand_bg = 1'b1;
    for (int i = 0; i < 400; i++) begin
      sel = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) begin
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
      end
      send(8'($urandom), 1'($urandom_range(0, 1)));
    end
    rand_bg   = 1'b0;
    ce        = 1'b1;
    out_ready = 1'b1;
    for (int t = 0; t < 100 && (qa.size() != 0 || qb.size() != 0); t++) @(negedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      vectors++;
      errors++;
      $display("FAIL drain_timeout: %0d/%0d results outstanding, required 0/0", qa.size(), qb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
